// File: rtl/store_block_if.sv
// Bundles the store_block control, source block and DMA write-side signals.
// master: the controller / DMA side; slave: store_block itself.
interface store_block_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WORDS  = 1024
);
  logic                         enable;
  logic [ADDR_WIDTH-1:0]        size;
  logic [ADDR_WIDTH-1:0]        address;
  logic signed [DATA_WIDTH-1:0] in [MAX_WORDS];
  logic                         dmaEnable;
  logic                         dmaRW;
  logic [ADDR_WIDTH-1:0]        dmaAddr;
  logic signed [DATA_WIDTH-1:0] dmaData;
  logic                         busy;
  logic                         done;

  modport master (
    output enable, size, address, in,
    input  dmaEnable, dmaRW, dmaAddr, dmaData, busy, done
  );

  modport slave (
    input  enable, size, address, in,
    output dmaEnable, dmaRW, dmaAddr, dmaData, busy, done
  );
endinterface

// File: rtl/store_block.sv
// store_block: writes a block of up to MAX_WORDS signed words to DMA memory from a base address.
// Define STORE_RELU_EN to clamp negative words to zero on the write path (same timing).
module store_block #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WORDS  = 1024
) (
  input logic          clk,
  input logic          reset,
  store_block_if.slave bus
);
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO    = {ADDR_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                       state_r;
  logic [ADDR_WIDTH-1:0]        base_r;
  logic [ADDR_WIDTH-1:0]        cnt_r;
  logic [ADDR_WIDTH-1:0]        index_r;
  logic                         dmaEnable_r;
  logic                         dmaRW_r;
  logic [ADDR_WIDTH-1:0]        dmaAddr_r;
  logic signed [DATA_WIDTH-1:0] dmaData_r;
  logic                         busy_r;
  logic                         done_r;

  logic [ADDR_WIDTH-1:0]        cntStart_s;
  logic [ADDR_WIDTH-1:0]        nextIndex_s;
  logic [ADDR_WIDTH-1:0]        wrAddr_s;
  logic signed [DATA_WIDTH-1:0] wrData_s;
  logic                         lastWord_s;

  function automatic logic signed [DATA_WIDTH-1:0] writeWord(input logic signed [DATA_WIDTH-1:0] w);
`ifdef STORE_RELU_EN
    writeWord = w[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : w;
`else
    writeWord = w;
`endif
  endfunction

  // Word to present on the next edge; index_r is always 0 while IDLE, so word 0 goes out on the start edge.
  always_comb begin
    cntStart_s  = (bus.size > MAX_CNT) ? MAX_CNT : bus.size;
    nextIndex_s = index_r + ONE;
    wrData_s    = writeWord(bus.in[index_r[IDX_W-1:0]]);
    wrAddr_s    = ZERO;
    lastWord_s  = 1'b0;
    if (state_r == IDLE) begin
      wrAddr_s   = bus.address;
      lastWord_s = (cntStart_s == ONE);
    end else begin
      wrAddr_s   = base_r + index_r;
      lastWord_s = (index_r == (cnt_r - ONE));
    end
  end

  // Control FSM with registered DMA, busy and done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      base_r      <= ZERO;
      cnt_r       <= ZERO;
      index_r     <= ZERO;
      dmaEnable_r <= 1'b0;
      dmaRW_r     <= 1'b0;
      dmaAddr_r   <= ZERO;
      dmaData_r   <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      dmaRW_r <= 1'b0;
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.enable) begin
            base_r <= bus.address;
            cnt_r  <= cntStart_s;
            if (cntStart_s == ZERO) begin
              dmaEnable_r <= 1'b0;
              busy_r      <= 1'b0;
              index_r     <= ZERO;
              state_r     <= DONE;
            end else begin
              dmaEnable_r <= 1'b1;
              dmaAddr_r   <= wrAddr_s;
              dmaData_r   <= wrData_s;
              busy_r      <= 1'b1;
              index_r     <= nextIndex_s;
              state_r     <= lastWord_s ? DONE : WRITE;
            end
          end else begin
            dmaEnable_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        WRITE: begin
          done_r <= 1'b0;
          if (bus.enable) begin
            dmaEnable_r <= 1'b1;
            dmaAddr_r   <= wrAddr_s;
            dmaData_r   <= wrData_s;
            busy_r      <= 1'b1;
            index_r     <= nextIndex_s;
            state_r     <= lastWord_s ? DONE : WRITE;
          end else begin
            // Abort: words already issued stay written, done is never raised.
            dmaEnable_r <= 1'b0;
            busy_r      <= 1'b0;
            index_r     <= ZERO;
            state_r     <= IDLE;
          end
        end
        DONE: begin
          dmaEnable_r <= 1'b0;
          busy_r      <= 1'b0;
          index_r     <= ZERO;
          if (bus.enable) begin
            done_r <= 1'b1;
          end else begin
            done_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          dmaEnable_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          index_r     <= ZERO;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.dmaEnable = dmaEnable_r;
  assign bus.dmaRW     = dmaRW_r;
  assign bus.dmaAddr   = dmaAddr_r;
  assign bus.dmaData   = dmaData_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_store_block.sv
// Directed bench for store_block: expected DMA writes are queued at stimulus time
// and popped as dmaEnable cycles appear.
module tb_store_block;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_block_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MW)) bus ();

  store_block #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   doneRises = 0;
  int   cycles = 0;
  logic prevDone = 1'b0;

  function automatic logic [15:0] expWord(input int i);
    logic [15:0] v;
    v = 16'(i - 12);
`ifdef STORE_RELU_EN
    if (i < 12) v = 16'd0;
`endif
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pushBlock(input logic [15:0] base, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = base + 16'(i);
      e.data = expWord(i);
      sbq.push_back(e);
    end
  endtask

  // One clock: sample just after the edge and score any DMA write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    cycles++;
    if (bus.dmaEnable === 1'b1) begin
      writes++;
      check("dmaRW", {31'd0, bus.dmaRW}, 32'd0);
      if (sbq.size() == 0) begin
        check("spurious_write", {31'd0, bus.dmaEnable}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("dmaAddr", {16'd0, bus.dmaAddr}, {16'd0, e.addr});
        check("dmaData", {16'd0, bus.dmaData}, {16'd0, e.data});
      end
    end
    if (bus.done === 1'b1 && prevDone !== 1'b1) doneRises++;
    prevDone = bus.done;
  endtask

  task automatic runWrites(input int target, input int budget);
    int b;
    b = budget;
    while (writes < target && b > 0) begin
      tick();
      b--;
    end
    check("write_count", 32'(writes), 32'(target));
  endtask

  initial begin
    int c0;
    int w0;
    int r0;
    reset       = 1'b0;
    bus.enable  = 1'b0;
    bus.size    = 16'd0;
    bus.address = 16'd0;
    for (int i = 0; i < MW; i++) bus.in[i] = 16'(i - 12);

    #2;
    check("rst_dmaEnable", {31'd0, bus.dmaEnable}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dmaAddr", {16'd0, bus.dmaAddr}, 32'd0);
    check("rst_dmaData", {16'd0, bus.dmaData}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic block: 25 words at 300.
    bus.size = 16'd25; bus.address = 16'd300; bus.enable = 1'b1;
    pushBlock(16'd300, 25);
    c0 = cycles; w0 = writes;
    tick();
    check("first_write_latency", {31'd0, bus.dmaEnable}, 32'd1);
    check("busy_in_write", {31'd0, bus.busy}, 32'd1);
    runWrites(w0 + 25, 40);
    check("consecutive_cycles", 32'(cycles - c0), 32'd25);
    tick();
    check("basic_dmaEnable_off", {31'd0, bus.dmaEnable}, 32'd0);
    check("basic_done", {31'd0, bus.done}, 32'd1);
    check("basic_busy_off", {31'd0, bus.busy}, 32'd0);
    check("addr_hold", {16'd0, bus.dmaAddr}, 32'd324);
    tick();
    check("done_held", {31'd0, bus.done}, 32'd1);
    bus.enable = 1'b0;
    tick();
    check("done_drop", {31'd0, bus.done}, 32'd0);
    check("basic_sb_empty", 32'(sbq.size()), 32'd0);

    // Zero size.
    bus.size = 16'd0; bus.address = 16'd40; bus.enable = 1'b1;
    w0 = writes;
    tick();
    check("zero_done_edge1", {31'd0, bus.done}, 32'd0);
    tick();
    check("zero_done_edge2", {31'd0, bus.done}, 32'd1);
    check("zero_no_writes", 32'(writes - w0), 32'd0);
    bus.enable = 1'b0;
    tick();
    check("zero_done_drop", {31'd0, bus.done}, 32'd0);

    // Address wrap.
    bus.size = 16'd4; bus.address = 16'hFFFE; bus.enable = 1'b1;
    pushBlock(16'hFFFE, 4);
    runWrites(writes + 4, 10);
    tick();
    check("wrap_done", {31'd0, bus.done}, 32'd1);
    bus.enable = 1'b0;
    tick();

    // Size clamp.
    bus.size = 16'd2000; bus.address = 16'h1000; bus.enable = 1'b1;
    pushBlock(16'h1000, 1024);
    w0 = writes;
    runWrites(w0 + 1024, 1100);
    tick(); tick(); tick();
    check("clamp_exact_1024", 32'(writes - w0), 32'd1024);
    check("clamp_done", {31'd0, bus.done}, 32'd1);
    bus.enable = 1'b0;
    tick();

    // Abort after 10 writes, then restart from index 0.
    r0 = doneRises; w0 = writes;
    bus.size = 16'd100; bus.address = 16'd500; bus.enable = 1'b1;
    pushBlock(16'd500, 10);
    runWrites(w0 + 10, 20);
    bus.enable = 1'b0;
    tick();
    check("abort_dmaEnable_off", {31'd0, bus.dmaEnable}, 32'd0);
    tick(); tick();
    check("abort_write_count", 32'(writes - w0), 32'd10);
    check("abort_no_done", 32'(doneRises - r0), 32'd0);
    bus.size = 16'd3; bus.enable = 1'b1;
    pushBlock(16'd500, 3);
    runWrites(w0 + 13, 10);
    tick();
    check("restart_done", {31'd0, bus.done}, 32'd1);
    bus.enable = 1'b0;
    tick();

    // Reset during the 5th write.
    bus.size = 16'd25; bus.address = 16'd700; bus.enable = 1'b1;
    pushBlock(16'd700, 25);
    w0 = writes;
    runWrites(w0 + 5, 10);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_dmaEnable", {31'd0, bus.dmaEnable}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    sbq.delete();
    bus.enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) tick();
    check("midrst_no_writes", 32'(writes - w0), 32'd5);
    check("midrst_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Back-to-back blocks.
    r0 = doneRises; w0 = writes;
    bus.size = 16'd6; bus.address = 16'd0; bus.enable = 1'b1;
    pushBlock(16'd0, 6);
    runWrites(w0 + 6, 12);
    tick();
    check("b2b_done1", {31'd0, bus.done}, 32'd1);
    bus.enable = 1'b0;
    tick();
    bus.address = 16'd50; bus.enable = 1'b1;
    pushBlock(16'd50, 6);
    runWrites(w0 + 12, 12);
    tick();
    check("b2b_done2", {31'd0, bus.done}, 32'd1);
    bus.enable = 1'b0;
    tick();
    check("b2b_done_pulses", 32'(doneRises - r0), 32'd2);
    check("b2b_writes", 32'(writes - w0), 32'd12);
    check("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_block.md
Name: store_block

Overview:
- Write-direction counterpart of load_block: takes a block of up to 1024 signed 16-bit results (conv/pool feature map) and writes it word-by-word into DMA memory starting at a base address.
- Sits between convolution_layer (producer of result blocks) and the DMA write port (RW=0).
- Uses the same enable/done handshake that convolution_layer already uses with load_block.

Parameters:
- DATA_WIDTH, 16, word width of data and DMA write bus
- ADDR_WIDTH, 16, DMA address width
- MAX_WORDS, 1024, depth of the source block array; upper clamp for size

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  start / hold request from the controller
- size  in  ADDR_WIDTH  number of words to write, sampled at start
- address  in  ADDR_WIDTH  base DMA address, sampled at start
- in  in  signed DATA_WIDTH x MAX_WORDS (unpacked array)  source block; must stay stable while busy=1
- dmaEnable  out  1  DMA access strobe
- dmaRW  out  1  DMA direction; always 0 (write) when dmaEnable=1
- dmaAddr  out  ADDR_WIDTH  DMA write address
- dmaData  out  signed DATA_WIDTH  DMA write data
- busy  out  1  high in WRITE state
- done  out  1  block fully written

Behaviour:
- All outputs are registered. While reset=0 (asynchronous): dmaEnable=0, dmaRW=0, dmaAddr=0, dmaData=0, busy=0, done=0, state=IDLE, index=0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - On enable=1, latch base=address and cnt=min(size, MAX_WORDS); index=0.
  - If cnt=0, go to DONE with no DMA write. Otherwise go to WRITE.
- WRITE: one word per cycle.
  - Drive dmaEnable=1, dmaRW=0, dmaAddr=(base+index) mod 2^ADDR_WIDTH, dmaData=in[index]; index increments.
  - First write is visible in the cycle after the start edge.
  - After the write with index=cnt-1, go to DONE. The next cycle has dmaEnable=0.
  - N words occupy exactly N consecutive dmaEnable cycles.
- DONE:
  - done=1 and busy=0; done is held while enable=1.
  - When enable=0, return to IDLE; done falls on the next edge.
  - A new block requires enable to drop and re-rise.
- Abort: enable=0 during WRITE aborts the block.
  - The next edge gives dmaEnable=0 and returns to IDLE; done is never asserted for an aborted block.
  - Words already written stay written.
- Address wrap: base+index wraps modulo 2^ADDR_WIDTH with no error flag.
- size > MAX_WORDS is silently clamped to MAX_WORDS.
- Reset asserted mid-WRITE: all outputs go to reset values immediately (asynchronously); no further writes occur.
- dmaAddr and dmaData hold their last values when dmaEnable=0. Only dmaEnable qualifies them.

Optional Feature:
- Macro: STORE_RELU_EN.
- Defined: dmaData = (in[index] < 0) ? 0 : in[index]. This applies ReLU on the write path with no added latency.
- Undefined: dmaData = in[index] unmodified. Timing and handshake are identical in both builds.

Test Plan:
- Basic: in[i]=i-12, size=25, address=300, enable held -> 25 consecutive dmaEnable cycles, dmaAddr 300..324, dmaRW=0; memory[300+i]=i-12 (or max(0,i-12) with STORE_RELU_EN); done=1 the cycle after the last write; done drops one edge after enable=0.
- Zero size: size=0, enable=1 -> no dmaEnable pulse; done=1 on the second edge after start.
- Wrap and clamp:
  - address=16'hFFFE, size=4 -> dmaAddr FFFE, FFFF, 0000, 0001.
  - size=2000 -> exactly 1024 writes.
- Abort: size=100, enable dropped after the 10th write -> exactly 10 writes (addresses base..base+9), done never asserted; a re-raised enable restarts from index 0.
- Reset mid-op: reset=0 during the 5th write of 25 -> dmaEnable, busy, done go to 0 immediately; after release with enable=0, the block stays IDLE with no writes.
- Back-to-back: two blocks (size=6 at 0, size=6 at 50) with enable toggled between -> 12 writes total, no overlap, done pulses once per block.
